// File: rtl/status_reg_if.sv
// Flag/control bundle between the core sequencer/ALU and the 6502 P register.
// master drives strobes and ALU flags; slave is the status register itself.
interface status_reg_if;
  logic       alu_n;
  logic       alu_v;
  logic       alu_z;
  logic       alu_c;
  logic       upd_nz;
  logic       upd_v;
  logic       upd_c;
  logic       set_c;
  logic       clr_c;
  logic       set_i;
  logic       clr_i;
  logic       set_d;
  logic       clr_d;
  logic       clr_v;
  logic       p_load;
  logic       p_load_rti;
  logic [7:0] p_in;
  logic       irq_ack;
  logic       instr_done;
  logic       brk_push;
  logic [2:0] cond;
  logic [7:0] p_out;
  logic [7:0] p_push;
  logic       alu_ci;
  logic       dec_mode;
  logic       irq_mask;
  logic       branch_taken;

  modport master (
    output alu_n, alu_v, alu_z, alu_c,
    output upd_nz, upd_v, upd_c,
    output set_c, clr_c, set_i, clr_i,
    output set_d, clr_d, clr_v,
    output p_load, p_load_rti, p_in,
    output irq_ack, instr_done,
    output brk_push, cond,
    input  p_out, p_push, alu_ci,
    input  dec_mode, irq_mask, branch_taken
  );

  modport slave (
    input  alu_n, alu_v, alu_z, alu_c,
    input  upd_nz, upd_v, upd_c,
    input  set_c, clr_c, set_i, clr_i,
    input  set_d, clr_d, clr_v,
    input  p_load, p_load_rti, p_in,
    input  irq_ack, instr_done,
    input  brk_push, cond,
    output p_out, p_push, alu_ci,
    output dec_mode, irq_mask, branch_taken
  );
endinterface

// File: rtl/status_reg.sv
// 6502 processor status register with branch eval and delayed I-mask.
// Define DECIMAL_EN to drive dec_mode from D; otherwise dec_mode is 0.
module status_reg (
  input  logic         clk,
  input  logic         rst_n,
  status_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HOLD = 2'd2
  } mask_st_t;

  logic     n, v, d, i, z, c;
  logic     n_nx, v_nx, d_nx, i_nx, z_nx, c_nx;
  logic     mask;
  mask_st_t st;
  logic     i_event;
  logic     i_now;
  logic     flag_sel;
  logic     unused;

  // Bits 5 and 4 of the pulled byte have no storage.
  assign unused = ^bus.p_in[5:4];

  // Next flag values: p_load, irq_ack, set, clr, ALU in falling priority.
  always_comb begin
    n_nx = n;
    v_nx = v;
    d_nx = d;
    i_nx = i;
    z_nx = z;
    c_nx = c;
    if (bus.p_load) begin
      n_nx = bus.p_in[7];
      v_nx = bus.p_in[6];
      d_nx = bus.p_in[3];
      i_nx = bus.p_in[2];
      z_nx = bus.p_in[1];
      c_nx = bus.p_in[0];
    end else begin
      if (bus.upd_nz) begin
        n_nx = bus.alu_n;
        z_nx = bus.alu_z;
      end
      if (bus.clr_v)
        v_nx = 1'b0;
      else if (bus.upd_v)
        v_nx = bus.alu_v;
      if (bus.set_c)
        c_nx = 1'b1;
      else if (bus.clr_c)
        c_nx = 1'b0;
      else if (bus.upd_c)
        c_nx = bus.alu_c;
      if (bus.set_d)
        d_nx = 1'b1;
      else if (bus.clr_d)
        d_nx = 1'b0;
      if (bus.irq_ack || bus.set_i)
        i_nx = 1'b1;
      else if (bus.clr_i)
        i_nx = 1'b0;
    end
  end

  // Delayed-mask triggers versus immediate (RTI / interrupt entry) ones.
  assign i_now   = (bus.p_load && bus.p_load_rti) || bus.irq_ack;
  assign i_event = bus.p_load ? !bus.p_load_rti
                              : (!bus.irq_ack && (bus.set_i || bus.clr_i));

  // Flag storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n <= 1'b0;
      v <= 1'b0;
      d <= 1'b0;
      i <= 1'b1;
      z <= 1'b0;
      c <= 1'b0;
    end else begin
      n <= n_nx;
      v <= v_nx;
      d <= d_nx;
      i <= i_nx;
      z <= z_nx;
      c <= c_nx;
    end
  end

  // Mask pipeline: CLI/SEI/PLP reach irq_mask one instruction late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= 1'b1;
      st   <= IDLE;
    end else if (i_now) begin
      mask <= i_nx;
      st   <= IDLE;
    end else if (i_event) begin
      st <= bus.instr_done ? HOLD : ARM;
    end else begin
      unique case (st)
        IDLE: st <= IDLE;
        ARM: begin
          if (bus.instr_done)
            st <= HOLD;
        end
        HOLD: begin
          if (bus.instr_done) begin
            mask <= i;
            st   <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  // Branch flag select from opcode bits [7:6].
  always_comb begin
    flag_sel = n;
    unique case (bus.cond[2:1])
      2'b00: flag_sel = n;
      2'b01: flag_sel = v;
      2'b10: flag_sel = c;
      2'b11: flag_sel = z;
      default: flag_sel = n;
    endcase
  end

  assign bus.branch_taken = (flag_sel == bus.cond[0]);
  assign bus.p_out  = {n, v, 1'b1, 1'b1, d, i, z, c};
  assign bus.p_push = {n, v, 1'b1, bus.brk_push, d, i, z, c};
  assign bus.alu_ci   = c;
  assign bus.irq_mask = mask;

`ifdef DECIMAL_EN
  assign bus.dec_mode = d;
`else
  assign bus.dec_mode = 1'b0;
`endif

endmodule

// File: tb/tb_status_reg.sv
// Scoreboard bench for status_reg: directed cases plus random strobes
// against a byte-level model of P and an instruction-count mask model.
module tb_status_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  status_reg_if bus ();

  status_reg u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit       alu_n, alu_v, alu_z, alu_c;
    bit       upd_nz, upd_v, upd_c;
    bit       set_c, clr_c, set_i, clr_i;
    bit       set_d, clr_d, clr_v;
    bit       p_load, p_load_rti;
    bit [7:0] p_in;
    bit       irq_ack, instr_done, brk_push;
    bit [2:0] cond;
  } stim_t;

  typedef struct packed {
    bit [7:0] p_out;
    bit [7:0] p_push;
    bit       alu_ci;
    bit       dec;
    bit       mask;
    bit       br;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  bit [7:0] mp;
  bit       mmask;
  int       pend;

  function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit dec_of(bit [7:0] p);
`ifdef DECIMAL_EN
    return p[3];
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit br_of(bit [7:0] p, bit [2:0] cd);
    bit [7:0] sel;
    int idx;
    sel = {8'd1, 8'd0, 8'd6, 8'd7};
    idx = 7;
    case (cd[2:1])
      2'd0: idx = 7;
      2'd1: idx = 6;
      2'd2: idx = 0;
      default: idx = 1;
    endcase
    return p[idx] == cd[0];
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.alu_n = s.alu_n;
    bus.alu_v = s.alu_v;
    bus.alu_z = s.alu_z;
    bus.alu_c = s.alu_c;
    bus.upd_nz = s.upd_nz;
    bus.upd_v = s.upd_v;
    bus.upd_c = s.upd_c;
    bus.set_c = s.set_c;
    bus.clr_c = s.clr_c;
    bus.set_i = s.set_i;
    bus.clr_i = s.clr_i;
    bus.set_d = s.set_d;
    bus.clr_d = s.clr_d;
    bus.clr_v = s.clr_v;
    bus.p_load = s.p_load;
    bus.p_load_rti = s.p_load_rti;
    bus.p_in = s.p_in;
    bus.irq_ack = s.irq_ack;
    bus.instr_done = s.instr_done;
    bus.brk_push = s.brk_push;
    bus.cond = s.cond;
  endtask

  task automatic model_reset();
    mp = 8'h04;
    mmask = 1'b1;
    pend = 0;
  endtask

  // Reference: P as a byte, mask delay as instruction-ends still owed.
  task automatic model(input stim_t s);
    bit [7:0] np;
    exp_t e;
    np = mp;
    if (s.p_load) begin
      np = s.p_in & 8'hCF;
    end else begin
      if (s.upd_nz) begin
        np[7] = s.alu_n;
        np[1] = s.alu_z;
      end
      if (s.clr_v) np[6] = 0;
      else if (s.upd_v) np[6] = s.alu_v;
      if (s.set_c) np[0] = 1;
      else if (s.clr_c) np[0] = 0;
      else if (s.upd_c) np[0] = s.alu_c;
      if (s.set_d) np[3] = 1;
      else if (s.clr_d) np[3] = 0;
      if (s.irq_ack || s.set_i) np[2] = 1;
      else if (s.clr_i) np[2] = 0;
    end
    if ((s.p_load && s.p_load_rti) || s.irq_ack) begin
      mmask = np[2];
      pend = 0;
    end else if (s.p_load || s.set_i || s.clr_i) begin
      pend = s.instr_done ? 1 : 2;
    end else if (pend > 0 && s.instr_done) begin
      pend--;
      if (pend == 0) mmask = mp[2];
    end
    mp = np;
    e.p_out = mp | 8'h30;
    e.p_push = (mp & 8'hCF) | 8'h20 | (s.brk_push ? 8'h10 : 8'h00);
    e.alu_ci = mp[0];
    e.dec = dec_of(mp);
    e.mask = mmask;
    e.br = br_of(mp, s.cond);
    sb.push_back(e);
  endtask

  task automatic step(input stim_t s);
    @(negedge clk);
    drive(s);
    model(s);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every registered update against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (rst_n && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("p_out", bus.p_out, e.p_out);
      chk("p_push", bus.p_push, e.p_push);
      chk("alu_ci", {7'd0, bus.alu_ci}, {7'd0, e.alu_ci});
      chk("dec_mode", {7'd0, bus.dec_mode}, {7'd0, e.dec});
      chk("irq_mask", {7'd0, bus.irq_mask}, {7'd0, e.mask});
      chk("branch", {7'd0, bus.branch_taken}, {7'd0, e.br});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic stim_t rnd();
    stim_t s;
    s = '0;
    s.alu_n = 1'($urandom);
    s.alu_v = 1'($urandom);
    s.alu_z = 1'($urandom);
    s.alu_c = 1'($urandom);
    s.upd_nz = ($urandom % 3) == 0;
    s.upd_v = ($urandom % 4) == 0;
    s.upd_c = ($urandom % 3) == 0;
    s.set_c = ($urandom % 8) == 0;
    s.clr_c = ($urandom % 8) == 0;
    s.set_i = ($urandom % 10) == 0;
    s.clr_i = ($urandom % 10) == 0;
    s.set_d = ($urandom % 8) == 0;
    s.clr_d = ($urandom % 8) == 0;
    s.clr_v = ($urandom % 8) == 0;
    s.p_load = ($urandom % 12) == 0;
    s.p_load_rti = 1'($urandom);
    s.p_in = 8'($urandom);
    s.irq_ack = !s.p_load && (($urandom % 16) == 0);
    s.instr_done = ($urandom % 3) == 0;
    s.brk_push = 1'($urandom);
    s.cond = 3'($urandom);
    return s;
  endfunction

  initial begin
    stim_t s;
    bit [7:0] tbl;
    int guard;
    drive(idle());
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst p_out", bus.p_out, 8'h34);
    chk("rst irq_mask", {7'd0, bus.irq_mask}, 8'd1);
    chk("rst alu_ci", {7'd0, bus.alu_ci}, 8'd0);
    chk("rst p_push b0", bus.p_push, 8'h24);
    chk("rst branch c0", {7'd0, bus.branch_taken}, 8'd1);
    bus.brk_push = 1'b1;
    #1;
    chk("rst p_push b1", bus.p_push, 8'h34);

    s = idle();
    s.alu_n = 1; s.alu_v = 1; s.alu_c = 1;
    s.upd_nz = 1; s.upd_c = 1;
    step(s);
    settle();
    chk("alu upd p_out", bus.p_out, 8'hB5);
    chk("alu upd ci", {7'd0, bus.alu_ci}, 8'd1);
    s.clr_c = 1;
    step(s);
    settle();
    chk("clr_c over alu", bus.p_out, 8'hB4);

    s = idle(); s.clr_i = 1; s.instr_done = 1;
    step(s);
    settle();
    chk("cli I", {7'd0, bus.p_out[2]}, 8'd0);
    chk("cli mask0", {7'd0, bus.irq_mask}, 8'd1);
    step(idle());
    step(idle());
    settle();
    chk("cli mask2", {7'd0, bus.irq_mask}, 8'd1);
    s = idle(); s.instr_done = 1;
    step(s);
    settle();
    chk("cli mask3", {7'd0, bus.irq_mask}, 8'd0);

    s = idle(); s.irq_ack = 1;
    step(s);
    settle();
    chk("irq_ack mask", {7'd0, bus.irq_mask}, 8'd1);
    s = idle(); s.p_load = 1; s.p_load_rti = 1; s.p_in = 8'hC3;
    step(s);
    settle();
    chk("rti p_out", bus.p_out, 8'hF3);
    chk("rti mask", {7'd0, bus.irq_mask}, 8'd0);
    s = idle(); s.p_load = 1; s.p_in = 8'h80; s.set_c = 1;
    step(s);
    settle();
    chk("plp over set_c", bus.p_out, 8'hB0);

    s = idle(); s.p_load = 1; s.p_load_rti = 1; s.p_in = 8'h83;
    step(s);
    tbl = 8'hA6;
    for (int k = 0; k < 8; k++) begin
      s = idle(); s.cond = 3'(k);
      step(s);
      settle();
      chk($sformatf("cond %0d", k), {7'd0, bus.branch_taken},
          {7'd0, tbl[k]});
    end

    s = idle(); s.set_d = 1;
    step(s);
    settle();
    chk("sed p_out3", {7'd0, bus.p_out[3]}, 8'd1);
`ifdef DECIMAL_EN
    chk("sed dec_mode", {7'd0, bus.dec_mode}, 8'd1);
`else
    chk("sed dec_mode", {7'd0, bus.dec_mode}, 8'd0);
`endif

    s = idle(); s.clr_i = 1;
    step(s);
    @(negedge clk);
    drive(idle());
    rst_n = 1'b0;
    #1;
    chk("midrst p_out", bus.p_out, 8'h34);
    chk("midrst mask", {7'd0, bus.irq_mask}, 8'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    s = idle(); s.instr_done = 1;
    repeat (3) step(s);

    for (int r = 0; r < 400; r++) step(rnd());
    step(idle());

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #3;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
